// File: rtl/seq_det_pkg.sv
// Shared types, defaults and helpers for the serial pattern detector.
package seq_det_pkg;

    localparam int PAT_MAX_DEF = 8;
    localparam int CNT_W_DEF   = 16;
    localparam int BYTE_W      = 8;
    localparam int LEN_W       = 4;
    localparam int MASK_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    function automatic logic [MASK_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        return (16'd1 << len) - 16'd1;
    endfunction

    // A zero length would match every bit, so it is promoted to one.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int pat_max);
        logic [LEN_W-1:0] lim;
        lim = LEN_W'(pat_max);
        if (len == 4'd0) begin
            return 4'd1;
        end else if (len > lim) begin
            return lim;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// Byte stream handshake between a data source and the detector.
interface seq_det_if;
    import seq_det_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [BYTE_W-1:0] s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/seq_pat_match.sv
// Bit history, seen-bit counter and masked pattern compare.
module seq_pat_match
    import seq_det_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_in,
    input  logic               bit_en,
    input  logic               clr,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);

    logic [PAT_MAX-1:0] hist_r;
    logic [PAT_MAX-1:0] hist_n_s;
    logic [PAT_MAX-1:0] mask_s;
    logic [LEN_W-1:0]   seen_r;
    logic [LEN_W-1:0]   seen_n_s;

    // Hit is judged on the history as it will look once this bit is in.
    always_comb begin
        hist_n_s = {hist_r[PAT_MAX-2:0], bit_in};
        seen_n_s = (seen_r == {LEN_W{1'b1}}) ? seen_r : seen_r + LEN_W'(1);
        mask_s   = PAT_MAX'(len_mask(len));
        hit      = bit_en && (seen_n_s >= len) &&
                   (((hist_n_s ^ pattern) & mask_s) == {PAT_MAX{1'b0}});
    end

    // History register; a non-overlapping hit restarts the search.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_r <= {PAT_MAX{1'b0}};
            seen_r <= {LEN_W{1'b0}};
        end else if (clr || (hit && !overlap)) begin
            hist_r <= {PAT_MAX{1'b0}};
            seen_r <= {LEN_W{1'b0}};
        end else if (bit_en) begin
            hist_r <= hist_n_s;
            seen_r <= seen_n_s;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Byte-stream serial pattern detector with match counter, threshold irq and halt.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               cfg_overlap,
    input  logic               start,
    input  logic               stop,
    seq_det_if.slave           bus,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               irq,
    input  logic               irq_clr,
    output logic               busy
);

    state_t             state_r, state_n_s;
    logic [PAT_MAX-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic [CNT_W-1:0]   thresh_r;
    logic               ovl_r, cfg_ok_r;
    logic [BYTE_W-1:0]  shreg_r;
    logic [2:0]         idx_r;
    logic               halt_pend_r, s_ready_r, busy_r, match_r, irq_r;
    logic [CNT_W-1:0]   cnt_r, cnt_inc_s;
    logic               go_s, abort_s, hs_s, bit_en_s, last_s, clr_s;
    logic               hit_s, set_irq_s, irq_ack_s;

    // Control decode shared by the FSM and the datapath.
    always_comb begin
        go_s      = (state_r == ST_IDLE) && start && !stop && cfg_ok_r;
        abort_s   = (state_r != ST_IDLE) && stop;
        hs_s      = (state_r == ST_WAIT) && bus.s_valid && !stop;
        bit_en_s  = (state_r == ST_SHIFT) && !stop;
        last_s    = (idx_r == 3'd7);
        clr_s     = go_s || abort_s;
        cnt_inc_s = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);
        set_irq_s = hit_s && (thresh_r != {CNT_W{1'b0}}) && (cnt_inc_s == thresh_r);
        irq_ack_s = (state_r == ST_HALT) && irq_clr && !stop;
    end

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE:  state_n_s = go_s ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                if (stop)      state_n_s = ST_IDLE;
                else if (hs_s) state_n_s = ST_SHIFT;
                else           state_n_s = ST_WAIT;
            end
            ST_SHIFT: begin
                if (stop)        state_n_s = ST_IDLE;
                else if (last_s) state_n_s = (halt_pend_r || set_irq_s) ? ST_HALT : ST_WAIT;
                else             state_n_s = ST_SHIFT;
            end
            ST_HALT: begin
                if (stop)         state_n_s = ST_IDLE;
                else if (irq_clr) state_n_s = ST_WAIT;
                else              state_n_s = ST_HALT;
            end
            default:  state_n_s = ST_IDLE;
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            s_ready_r <= (state_n_s == ST_WAIT);
            busy_r    <= (state_n_s != ST_IDLE);
        end
    end

    // Configuration is only writable while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_r    <= {PAT_MAX{1'b0}};
            len_r    <= {LEN_W{1'b0}};
            thresh_r <= {CNT_W{1'b0}};
            ovl_r    <= 1'b0;
            cfg_ok_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && cfg_we) begin
            pat_r    <= cfg_pattern;
            len_r    <= clamp_len(cfg_len, PAT_MAX);
            thresh_r <= cfg_thresh;
            ovl_r    <= cfg_overlap;
            cfg_ok_r <= 1'b1;
        end
    end

    // Byte shifter, MSB first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_r <= {BYTE_W{1'b0}};
            idx_r   <= 3'd0;
        end else if (hs_s) begin
            shreg_r <= bus.s_data;
            idx_r   <= 3'd0;
        end else if (bit_en_s) begin
            shreg_r <= {shreg_r[BYTE_W-2:0], 1'b0};
            idx_r   <= idx_r + 3'd1;
        end
    end

    // Match pulse, counter and irq; an irq set beats a coincident clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_r     <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            irq_r       <= 1'b0;
            halt_pend_r <= 1'b0;
        end else begin
            match_r     <= hit_s;
            halt_pend_r <= (bit_en_s && !last_s) ? (halt_pend_r | set_irq_s) : 1'b0;
            if (go_s || irq_ack_s) cnt_r <= {CNT_W{1'b0}};
            else if (hit_s)        cnt_r <= cnt_inc_s;
            if (set_irq_s)         irq_r <= 1'b1;
            else if (irq_ack_s)    irq_r <= 1'b0;
        end
    end

    seq_pat_match #(.PAT_MAX(PAT_MAX)) u_match (
        .clk     (clk),
        .reset   (reset),
        .bit_in  (shreg_r[BYTE_W-1]),
        .bit_en  (bit_en_s),
        .clr     (clr_s),
        .pattern (pat_r),
        .len     (len_r),
        .overlap (ovl_r),
        .hit     (hit_s)
    );

    assign bus.s_ready = s_ready_r;
    assign busy        = busy_r;
    assign match       = match_r;
    assign match_cnt   = cnt_r;
    assign irq         = irq_r;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a bit-list reference model predicts match pulses.
module tb_seq_det_ctrl;
    import seq_det_pkg::*;

    localparam int PM = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0, cfg_overlap = 1'b0, start = 1'b0, stop = 1'b0, irq_clr = 1'b0;
    logic [PM-1:0] cfg_pattern = '0;
    logic [3:0]    cfg_len = '0;
    logic [CW-1:0] cfg_thresh = '0;
    logic          match, irq, busy;
    logic [CW-1:0] match_cnt;

    seq_det_if bus();

    seq_det_ctrl #(.PAT_MAX(PM), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .cfg_overlap(cfg_overlap),
        .start(start), .stop(stop), .bus(bus), .match(match), .match_cnt(match_cnt),
        .irq(irq), .irq_clr(irq_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int cnt; } exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0, n_fail = 0;
    int   cyc = 0, hs_cyc = -100;

    // Reference model: list of bits received since the last restart.
    int          m_bits[$];
    int          m_cnt = 0, m_len = 1, m_thr = 0;
    logic [7:0]  m_pat = '0;
    bit          m_ovl = 1'b0;

    task automatic chk(string nm, longint act, longint req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic void m_config(logic [7:0] pat, int len, bit ovl, int thr);
        m_pat = pat;
        m_len = (len == 0) ? 1 : ((len > PM) ? PM : len);
        m_ovl = ovl;
        m_thr = thr;
    endfunction

    // Returns 1 when the threshold is reached within these bits.
    function automatic bit m_feed(logic [7:0] b, int nbits);
        bit halt = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            bit ok = 1'b1;
            m_bits.push_back(int'(b[7-k]));
            if (m_bits.size() > 16) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
                for (int j = 0; j < m_len; j++)
                    if (m_bits[m_bits.size()-1-j] != int'(m_pat[j])) ok = 1'b0;
                if (ok) begin
                    if (m_cnt < 65535) m_cnt++;
                    exp_q.push_back('{k, m_cnt});
                    if (m_thr != 0 && m_cnt == m_thr) halt = 1'b1;
                    if (!m_ovl) m_bits.delete();
                end
            end
        end
        return halt;
    endfunction

    // Monitor: every match pulse must correspond to the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (match === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_match: actual pulse cnt=%0d required no pulse (t=%0t)",
                         match_cnt, $time);
            end else begin
                e = exp_q.pop_front();
                chk("match_bit_idx", cyc - hs_cyc - 2, e.idx);
                chk("match_cnt_at_pulse", match_cnt, e.cnt);
            end
        end
        if (bus.s_valid && bus.s_ready) hs_cyc = cyc;
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_cfg(logic [7:0] pat, int len, bit ovl, int thr);
        cfg_pattern = pat;
        cfg_len     = 4'(len);
        cfg_overlap = ovl;
        cfg_thresh  = CW'(thr);
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic do_cfg(logic [7:0] pat, int len, bit ovl, int thr);
        drive_cfg(pat, len, ovl, thr);
        m_config(pat, len, ovl, thr);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_bits.delete();
        m_cnt = 0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        m_bits.delete();
    endtask

    // Returns one cycle after the handshake, i.e. during the first bit.
    task automatic send(logic [7:0] b);
        int t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (!bus.s_ready && t < 40) begin
            tick();
            t++;
        end
        if (!bus.s_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: actual s_ready=0 required 1 within 40 cycles");
        end else begin
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        tick(12);
        chk("pending_matches", exp_q.size(), 0);
    endtask

    initial begin
        bit halt;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #2 reset = 1'b0;
        #1 chk("reset_outputs", {match, match_cnt, irq, busy, bus.s_ready}, 0);
        tick(2);
        reset = 1'b1;
        tick();

        // Overlapping 1101 in 0xDB: hits on bits 3 and 6.
        do_cfg(8'b1101, 4, 1'b1, 0);
        do_start();
        chk("busy_after_start", busy, 1);
        chk("ready_in_wait", bus.s_ready, 1);
        void'(m_feed(8'hDB, 8));
        send(8'hDB);
        drain();
        chk("ovl_cnt", match_cnt, 2);
        do_stop();
        chk("idle_after_stop", busy, 0);

        // Non-overlapping: only bit 3.
        do_cfg(8'b1101, 4, 1'b0, 0);
        do_start();
        void'(m_feed(8'hDB, 8));
        send(8'hDB);
        drain();
        chk("novl_cnt", match_cnt, 1);
        do_stop();

        // Pattern spanning a byte boundary.
        do_cfg(8'b1101, 4, 1'b1, 0);
        do_start();
        void'(m_feed(8'h06, 8));
        send(8'h06);
        void'(m_feed(8'h80, 8));
        send(8'h80);
        drain();
        chk("span_cnt", match_cnt, 1);
        do_stop();

        // Threshold reached: irq, halt after the byte, then irq_clr resumes.
        do_cfg(8'b1101, 4, 1'b1, 2);
        do_start();
        halt = m_feed(8'hDB, 8);
        send(8'hDB);
        tick(9);
        chk("thr_irq", irq, halt);
        chk("thr_halt_ready", bus.s_ready, 0);
        chk("thr_halt_busy", busy, 1);
        chk("thr_cnt", match_cnt, m_cnt);
        tick(3);
        chk("thr_still_halted", bus.s_ready, 0);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        m_cnt = 0;
        chk("clr_irq", irq, 0);
        chk("clr_cnt", match_cnt, m_cnt);
        chk("clr_ready", bus.s_ready, 1);
        chk("thr_pending", exp_q.size(), 0);
        do_stop();

        // Async reset in the middle of a byte.
        do_cfg(8'b11, 2, 1'b1, 0);
        do_start();
        void'(m_feed(8'hFF, 8));
        send(8'hFF);
        tick(4);
        chk("pre_reset_cnt", match_cnt, 3);
        reset = 1'b0;
        #1 chk("midshift_reset", {match, match_cnt, irq, busy, bus.s_ready}, 0);
        exp_q.delete();
        tick(2);
        reset = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_needs_cfg", busy, 0);
        do_cfg(8'b1101, 4, 1'b1, 0);
        do_start();
        drive_cfg(8'hFF, 8, 1'b0, 0);
        void'(m_feed(8'hDB, 8));
        send(8'hDB);
        drain();
        chk("cfg_ignored_in_wait", match_cnt, m_cnt);
        do_stop();

        // Stop during bit 2: remaining bits dropped, count held.
        do_cfg(8'b11, 2, 1'b1, 0);
        do_start();
        void'(m_feed(8'hFF, 2));
        send(8'hFF);
        tick(2);
        do_stop();
        chk("stop_to_idle", busy, 0);
        tick(10);
        chk("stop_cnt_held", match_cnt, m_cnt);
        chk("stop_pending", exp_q.size(), 0);

        // Randomized configurations and streams.
        for (int it = 0; it < 30; it++) begin
            logic [7:0] pat = 8'($urandom);
            int len = $urandom_range(0, 15);
            bit ovl = 1'($urandom);
            int nb  = $urandom_range(2, 5);
            do_cfg(pat, len, ovl, 0);
            do_start();
            for (int i = 0; i < nb; i++) begin
                logic [7:0] b = ($urandom_range(0, 2) == 0) ? pat : 8'($urandom);
                tick($urandom_range(0, 3));
                void'(m_feed(b, 8));
                send(b);
            end
            drain();
            chk("rand_cnt", match_cnt, m_cnt);
            do_stop();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
